// File: rtl/inst_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_pkg
// Shared definitions for the instruction memory loader slice: bus typedefs,
// the NOP word, chip-enable levels, the loader state encoding, the default
// memory size and a helper that assembles a big-endian word from the byte
// assembler contents.
// ---------------------------------------------------------------------------
package inst_mem_loader_pkg;

    // Core-side bus widths (byte address from the PC, 32-bit instruction word)
    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_DATA_WIDTH = 32;

    typedef logic [INST_ADDR_WIDTH-1:0] inst_addr_bus_t;
    typedef logic [INST_DATA_WIDTH-1:0] inst_data_bus_t;

    // All-zero word doubles as the NOP returned for masked fetches
    localparam inst_data_bus_t ZERO_WORD = '0;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Default word-address width: 1024 words of instruction memory
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // Loader FSM: streaming the image in, or image complete and fetch live
    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } load_state_e;

    // Builds the word to be written when the byte at position byte_idx is
    // accepted. The shift register holds earlier bytes with the oldest byte
    // highest, so fewer held bytes means more zero-padded low bytes.
    function automatic inst_data_bus_t assemble_word(
        input logic [23:0] shift_bytes,
        input logic [1:0]  byte_idx,
        input logic [7:0]  new_byte
    );
        case (byte_idx)
            2'd0:    return {new_byte, 24'h000000};
            2'd1:    return {shift_bytes[7:0], new_byte, 16'h0000};
            2'd2:    return {shift_bytes[15:0], new_byte, 8'h00};
            default: return {shift_bytes, new_byte};
        endcase
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_if
// Bundles the load stream, the core fetch port and the loader status lines.
//   ld_valid_i / ld_byte_i / ld_last_i / ld_ready_o : byte-wide load stream
//   rom_ce_i / rom_addr_i / rom_data_o               : core fetch port
//   core_hold_o, load_done_o, load_err_o, word_count_o : loader status
// master: the side feeding bytes and fetching (loader host + core).
// slave:  the inst_mem_loader itself.
// ---------------------------------------------------------------------------
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

    logic                ld_valid_i;
    logic [7:0]          ld_byte_i;
    logic                ld_last_i;
    logic                ld_ready_o;

    logic                rom_ce_i;
    inst_addr_bus_t      rom_addr_i;
    inst_data_bus_t      rom_data_o;

    logic                core_hold_o;
    logic                load_done_o;
    logic                load_err_o;
    logic [ADDR_WIDTH:0] word_count_o;

    modport master (
        output ld_valid_i, ld_byte_i, ld_last_i, rom_ce_i, rom_addr_i,
        input  ld_ready_o, rom_data_o, core_hold_o, load_done_o,
               load_err_o, word_count_o
    );

    modport slave (
        input  ld_valid_i, ld_byte_i, ld_last_i, rom_ce_i, rom_addr_i,
        output ld_ready_o, rom_data_o, core_hold_o, load_done_o,
               load_err_o, word_count_o
    );

endinterface

// File: rtl/inst_mem_loader_inst_ram.sv
// ---------------------------------------------------------------------------
// inst_ram
// DEPTH x DATA_WIDTH instruction storage with one synchronous write port and
// one asynchronous read port. Contents are never cleared; the loader masks
// words that have not been written since the last reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module inst_ram
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = INST_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Single write port; storage has no reset so it maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the core gets its instruction in the same
    // cycle it presents the PC
    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Instruction memory that is filled after reset from a byte-wide valid/ready
// stream and then serves the core's fetch port combinationally. The core is
// held in reset until the image is complete.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : inst_mem_loader_if.slave
//         ld_*          load stream in (big-endian bytes, last on final byte)
//         ld_ready_o    high while loading and out of reset
//         rom_*         fetch port; masked words read back as zero
//         core_hold_o   keeps the core in reset until the load completes
//         load_done_o   image loaded
//         load_err_o    sticky: image was larger than the memory
//         word_count_o  number of words written since reset
// ---------------------------------------------------------------------------
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    inst_mem_loader_if.slave bus
);

    localparam int                  DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    load_state_e           state;
    logic [1:0]            byte_idx;
    logic [23:0]           shift_q;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  load_err;

    logic                  ld_ready;
    logic                  accept;
    logic                  word_complete;
    logic                  mem_full;
    logic                  ram_we;
    inst_data_bus_t        ram_wdata;
    inst_data_bus_t        ram_rdata;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_hit;
    logic                  load_done;
    logic                  unused_addr_bits;

    // Ready depends on rst directly so bytes offered during reset are never
    // accepted and ready is up in the very first cycle after release
    assign ld_ready = rst && (state == LOAD);

    // Handshake and word-write decode shared by the FSM and the RAM port.
    // A word is closed either by its fourth byte or by the last byte of the
    // image; when the memory is already full the write is dropped.
    always_comb begin
        accept        = bus.ld_valid_i && ld_ready;
        word_complete = accept && ((byte_idx == 2'd3) || bus.ld_last_i);
        mem_full      = (word_count == DEPTH_COUNT);
        ram_we        = word_complete && !mem_full;
        ram_wdata     = assemble_word(shift_q, byte_idx, bus.ld_byte_i);
    end

    // Loader FSM, byte assembler and counters. Word write, count increment
    // and the move to DONE all happen on the edge that accepts the closing
    // byte. Reset clears progress but leaves the RAM contents alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            byte_idx   <= 2'd0;
            shift_q    <= 24'h000000;
            word_count <= '0;
            load_err   <= 1'b0;
        end else if (accept) begin
            if (word_complete) begin
                byte_idx <= 2'd0;
                shift_q  <= 24'h000000;
                if (mem_full) begin
                    load_err <= 1'b1;
                end else begin
                    word_count <= word_count + 1'b1;
                end
            end else begin
                byte_idx <= byte_idx + 2'd1;
                shift_q  <= {shift_q[15:0], bus.ld_byte_i};
            end
            if (bus.ld_last_i) begin
                state <= DONE;
            end
        end
    end

    inst_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (INST_DATA_WIDTH)
    ) u_inst_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_count[ADDR_WIDTH-1:0]),
        .wdata (ram_wdata),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // Fetch mask: only words written since reset, inside the memory's
    // address window, with the core enabled and the load finished are
    // returned; everything else reads as a NOP. Byte offset bits are
    // don't-care because fetches are word aligned.
    assign fetch_idx        = bus.rom_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^bus.rom_addr_i[1:0];
    assign load_done        = (state == DONE);

    always_comb begin
        fetch_hit = load_done
                 && (bus.rom_ce_i == CHIP_ENABLE)
                 && ({1'b0, fetch_idx} < word_count)
                 && (bus.rom_addr_i[INST_ADDR_WIDTH-1:ADDR_WIDTH+2] == '0);
        bus.rom_data_o = fetch_hit ? ram_rdata : ZERO_WORD;
    end

    assign bus.ld_ready_o   = ld_ready;
    assign bus.core_hold_o  = !load_done;
    assign bus.load_done_o  = load_done;
    assign bus.load_err_o   = load_err;
    assign bus.word_count_o = word_count;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Instruction memory feeding the core's fetch port (rom_ce / rom_addr / rom_data), filled after reset from a byte-wide valid/ready load stream. It holds the core in reset until the program is loaded, then serves fetches combinationally in the same cycle the PC is presented. It sits directly upstream of the core's IF stage and replaces a preloaded instruction ROM.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth DEPTH = 2^ADDR_WIDTH words.
- INST_WIDTH, 32: instruction width; fixed to the core's instruction data bus.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- ld_valid_i  in  1  load byte valid.
- ld_byte_i  in  8  load byte; big-endian within each word.
- ld_last_i  in  1  qualifies the final byte of the image.
- ld_ready_o  out  1  accepts a byte this cycle.
- rom_ce_i  in  1  fetch enable from the core.
- rom_addr_i  in  32  byte address from the core PC.
- rom_data_o  out  32  instruction word.
- core_hold_o  out  1  keep the core in reset while 1.
- load_done_o  out  1  image loaded; fetch port live.
- load_err_o  out  1  sticky overflow: image exceeded DEPTH words.
- word_count_o  out  ADDR_WIDTH+1  words written so far.

## Operation
- FSM states: LOAD, DONE. Reset enters LOAD.
- LOAD: ld_ready_o=1. A byte is accepted when ld_valid_i && ld_ready_o.
- Byte assembly: a 2-bit byte index and a 24-bit shift register hold bytes 0..2. The first byte of a word lands in bits 31:24.
- Word write on acceptance of the 4th byte: mem[word_count] <= {shift, ld_byte_i}; word_count++; byte index -> 0.
- ld_last_i on an accepted byte: the current word is written, with unsent low bytes zero-padded, even if the word is partial. Then LOAD -> DONE.
- Overflow: a word write with word_count==DEPTH is suppressed and sets load_err_o. word_count saturates at DEPTH. Bytes continue to be accepted until last.
- DONE: ld_ready_o=0, and load bytes are ignored. Only reset reloads.
- Fetch read: idx = rom_addr_i[ADDR_WIDTH+1:2].
  - rom_data_o = mem[idx] when load_done_o && rom_ce_i && idx < word_count && rom_addr_i[31:ADDR_WIDTH+2]==0.
  - Otherwise rom_data_o = 0 (NOP).
  - rom_addr_i[1:0] is ignored.
- core_hold_o = !load_done_o.
- Memory contents are not cleared by reset. Unwritten words are masked by the word_count compare.

## Timing
- Reset values: state LOAD, ld_ready_o 1 in the first cycle after reset release (0 while rst=0), core_hold_o 1, load_done_o 0, load_err_o 0, word_count_o 0, byte index 0, rom_data_o 0.
- Throughput: one byte per cycle, so 4 cycles per word. There are no bubbles between words.
- Word write, word_count increment, and LOAD->DONE all take effect on the same clk edge that accepts the completing or last byte.
- load_done_o rises and core_hold_o falls on that edge. The first fetch is possible the following cycle.
- Fetch read latency is 0 cycles: combinational from rom_addr_i/rom_ce_i, which matches the core's IF/ID register sampling.
- Simultaneous last byte and overflow: the error is set, the write is dropped, and the state still goes to DONE.
- Reset mid-load: the partial word is discarded, word_count returns to 0, and the FSM returns to LOAD on the next edge with rst=0.
- ld_valid_i while rst=0: ignored.

## Structure
- Shared defines file: InstAddrBus, InstDataBus, ZeroWord, ChipEnable/ChipDisable. Add the LOAD/DONE state encodings and default ADDR_WIDTH there.
- Sub-module inst_ram: DEPTH x 32 array, one synchronous write port (we, waddr, wdata), one asynchronous read port (raddr, rdata).
- inst_mem_loader contains the FSM, byte assembler, counters, and the fetch-mask logic.

## Test plan
- Reset, then stream 8 bytes 34 01 00 01 34 02 00 02 with last on byte 8:
  - word_count_o=2 and load_done_o=1 on the 8th accept edge.
  - Fetch at 0x0 gives 0x34010001; fetch at 0x4 gives 0x34020002.
- Partial image: 5 bytes AA BB CC DD EE, last on EE. Fetch at 0x4 gives 0xEE000000; word_count_o=2.
- Masking:
  - After a 2-word load, a fetch at 0x8 gives 0.
  - A fetch at 0x0 with rom_ce_i=0 gives 0.
  - Address 0x1000 with ADDR_WIDTH=10 gives 0.
- Overflow with ADDR_WIDTH=2: stream 5 words. load_err_o=1, word_count_o=4, and words 0..3 are intact.
- Reset asserted after 6 bytes:
  - Next cycle: word_count_o=0, core_hold_o=1.
  - Reload of 4 bytes 11 22 33 44 gives 0x11223344 at 0x0.
- ld_valid_i toggled randomly: the byte order is preserved. In DONE, further bytes are not accepted (ld_ready_o=0) and contents are unchanged.
